// File: rtl/sh_deser_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: default word
// width, counter width helper and the holding-buffer state encoding.
package sh_deser_pkg;

    localparam int W_DEFAULT = 8;

    // Width of a counter that must hold the values 0 .. w-1.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_HOLD  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/sh_deser_buf.sv
// One-word holding buffer with a valid/ready handshake and a sticky
// overflow flag for completed words that arrive while the buffer is full.
module sh_deser_buf
    import sh_deser_pkg::*;
#(
    parameter int w = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         clr,
    input  logic [w-1:0] word,
    input  logic         word_stb,
    input  logic         q_rdy,
    output logic [w-1:0] q_out,
    output buf_state_t   state,
    output logic         ovf
);

    // Handshake: a word transfers on a rising edge where the buffer is in
    // HOLD and q_rdy=1. q_out is stable for as long as the buffer is in HOLD.
    // A word completing in the same edge as a transfer refills the buffer
    // with no bubble; a word completing while HOLD is stalled is dropped.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= BUF_EMPTY;
            q_out <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            state <= BUF_EMPTY;
            q_out <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (word_stb) begin
                        q_out <= word;
                        state <= BUF_HOLD;
                    end
                end
                BUF_HOLD: begin
                    if (word_stb) begin
                        if (q_rdy) begin
                            q_out <= word;
                        end else begin
                            ovf <= 1'b1;
                        end
                    end else if (q_rdy) begin
                        state <= BUF_EMPTY;
                    end
                end
                default: state <= BUF_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/sh_deser.sv
// Serial-to-parallel deserializer: collects LSB-first bits into w-bit words
// and hands each completed word to a one-word holding buffer.
module sh_deser
    import sh_deser_pkg::*;
#(
    parameter  int w  = W_DEFAULT,
    localparam int CW = cnt_width(w)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          clr,
    input  logic          sin,
    input  logic          sin_en,
    output logic [w-1:0]  q_out,
    output logic          q_vld,
    input  logic          q_rdy,
    output logic [CW-1:0] bit_cnt,
    output logic          ovf
);

    localparam logic [CW-1:0] LAST = CW'(w - 1);

    logic [w-1:0] sr;
    logic [w-1:0] word;
    logic         word_stb;
    buf_state_t   buf_state;

    // New bits enter at the top so the first bit received ends up in bit 0.
    assign word     = {sin, sr[w-1:1]};
    assign word_stb = sin_en && (bit_cnt == LAST);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (sin_en) begin
            sr      <= word;
            bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
        end
    end

    sh_deser_buf #(
        .w (w)
    ) u_buf (
        .clk      (clk),
        .rst_b    (rst_b),
        .clr      (clr),
        .word     (word),
        .word_stb (word_stb),
        .q_rdy    (q_rdy),
        .q_out    (q_out),
        .state    (buf_state),
        .ovf      (ovf)
    );

    assign q_vld = (buf_state == BUF_HOLD);

endmodule

// File: tb/tb_sh_deser.sv
// Bench for sh_deser: directed bit streams, a bit-position model of the
// word collector and holding buffer, and an expected-word queue for ordering.
module tb_sh_deser;

    localparam int W  = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          clr;
    logic          sin;
    logic          sin_en;
    logic          q_rdy;
    logic [W-1:0]  q_out;
    logic          q_vld;
    logic [CW-1:0] bit_cnt;
    logic          ovf;

    // Upstream parallel-load shift register with a registered serial output.
    logic          chain = 1'b0;
    logic          up_load = 1'b0;
    logic          up_sh = 1'b0;
    logic [W-1:0]  up_din = '0;
    logic [W-1:0]  up_r = '0;
    logic          up_so = 1'b0;
    logic          up_sh_d = 1'b0;
    logic          dut_sin;
    logic          dut_sin_en;

    assign dut_sin    = chain ? up_so   : sin;
    assign dut_sin_en = chain ? up_sh_d : sin_en;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (up_load) begin
            up_r <= up_din;
        end else if (up_sh) begin
            up_so <= up_r[0];
            up_r  <= up_r >> 1;
        end
        up_sh_d <= up_sh;
    end

    sh_deser #(.w(W)) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .clr     (clr),
        .sin     (dut_sin),
        .sin_en  (dut_sin_en),
        .q_out   (q_out),
        .q_vld   (q_vld),
        .q_rdy   (q_rdy),
        .bit_cnt (bit_cnt),
        .ovf     (ovf)
    );

    int checks = 0;
    int errors = 0;
    logic run = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bits are placed by arrival position; words go to a one-slot buffer.
    int           m_cnt;
    logic [W-1:0] m_acc;
    logic [W-1:0] m_q;
    logic         m_vld;
    logic         m_ovf;
    logic [W-1:0] exp_q[$];

    always @(posedge clk or negedge rst_b) begin
        logic         done;
        logic [W-1:0] w_new;
        logic         take;
        if (!rst_b || clr) begin
            m_cnt = 0; m_acc = '0; m_q = '0; m_vld = 1'b0; m_ovf = 1'b0;
            exp_q.delete();
        end else begin
            take  = m_vld && q_rdy;
            done  = 1'b0;
            w_new = '0;
            if (dut_sin_en) begin
                m_acc[m_cnt] = dut_sin;
                m_cnt++;
                if (m_cnt == W) begin
                    done = 1'b1; w_new = m_acc; m_cnt = 0; m_acc = '0;
                end
            end
            if (done) begin
                if (!m_vld || q_rdy) begin
                    m_q = w_new; m_vld = 1'b1; exp_q.push_back(w_new);
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (take) begin
                m_vld = 1'b0;
            end
        end
    end

    // Compare process: outputs every cycle, delivered words in order.
    always @(negedge clk) begin
        if (run && rst_b) begin
            check("q_out", q_out, m_q);
            check("q_vld", q_vld, m_vld);
            check("bit_cnt", bit_cnt, m_cnt);
            check("ovf", ovf, m_ovf);
            if (m_vld && q_rdy && !clr) begin
                if (exp_q.size() == 0) begin
                    check("order_queue_empty", 1, 0);
                end else begin
                    check("order", q_out, exp_q.pop_front());
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b);
        cycle();
        sin = b;
        sin_en = 1'b1;
    endtask

    task automatic send_word(input logic [W-1:0] wd, input int gap_max);
        for (int i = 0; i < W; i++) begin
            int gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (gap) begin
                cycle();
                sin_en = 1'b0;
            end
            send_bit(wd[i]);
        end
        cycle();
        sin_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] v;
        rst_b = 1'b0; clr = 1'b0; sin = 1'b0; sin_en = 1'b0; q_rdy = 1'b0;
        #12;
        check("rst_q_out", q_out, 0);
        check("rst_q_vld", q_vld, 0);
        check("rst_bit_cnt", bit_cnt, 0);
        check("rst_ovf", ovf, 0);
        cycle();
        rst_b = 1'b1;
        run = 1'b1;

        // 1: single word, consumer ready
        q_rdy = 1'b1;
        send_word(8'hA5, 0);
        check("t1_q_out", q_out, 8'hA5);
        check("t1_q_vld", q_vld, 1);
        check("t1_bit_cnt", bit_cnt, 0);
        check("t1_ovf", ovf, 0);
        cycle();
        check("t1_drained", q_vld, 0);

        // 2: two words with idle gaps
        send_word(8'h3C, 3);
        check("t2_first", q_out, 8'h3C);
        send_word(8'hC3, 3);
        check("t2_second", q_out, 8'hC3);
        check("t2_ovf", ovf, 0);
        cycle();

        // 3: overflow while stalled
        q_rdy = 1'b0;
        send_word(8'h12, 0);
        send_word(8'h34, 0);
        check("t3_q_out", q_out, 8'h12);
        check("t3_q_vld", q_vld, 1);
        check("t3_ovf", ovf, 1);
        q_rdy = 1'b1;
        cycle();
        q_rdy = 1'b0;
        check("t3_drain_vld", q_vld, 0);
        check("t3_ovf_sticky", ovf, 1);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check("t3_clr_ovf", ovf, 0);

        // 4: drain and completion on the same edge
        send_word(8'h55, 0);
        check("t4_hold", q_out, 8'h55);
        v = 8'hAA;
        for (int i = 0; i < W - 1; i++) send_bit(v[i]);
        send_bit(v[W-1]);
        q_rdy = 1'b1;
        cycle();
        sin_en = 1'b0;
        q_rdy = 1'b0;
        check("t4_q_out", q_out, 8'hAA);
        check("t4_q_vld", q_vld, 1);
        check("t4_ovf", ovf, 0);
        q_rdy = 1'b1;
        cycle();
        q_rdy = 1'b0;

        // 5a: clr mid-word
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        cycle();
        sin_en = 1'b0;
        check("t5_partial_cnt", bit_cnt, 3);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check("t5_clr_cnt", bit_cnt, 0);
        send_word(8'h81, 0);
        check("t5_after_clr", q_out, 8'h81);

        // 5b: asynchronous reset mid-word, with a word still held
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        cycle();
        sin_en = 1'b0;
        rst_b = 1'b0;
        #1;
        check("t5_arst_q_out", q_out, 0);
        check("t5_arst_q_vld", q_vld, 0);
        check("t5_arst_cnt", bit_cnt, 0);
        check("t5_arst_ovf", ovf, 0);
        #1;
        rst_b = 1'b1;
        send_word(8'h81, 0);
        check("t5_after_rst", q_out, 8'h81);
        q_rdy = 1'b1;
        cycle();
        q_rdy = 1'b0;

        // 6: chained to the upstream shift register
        chain = 1'b1;
        up_din = 8'h96;
        up_load = 1'b1;
        cycle();
        up_load = 1'b0;
        up_sh = 1'b1;
        repeat (W) cycle();
        up_sh = 1'b0;
        cycle();
        check("t6_q_out", q_out, 8'h96);
        check("t6_q_vld", q_vld, 1);
        check("t6_bit_cnt", bit_cnt, 0);
        chain = 1'b0;

        q_rdy = 1'b1;
        repeat (2) cycle();
        check("end_empty", q_vld, 0);
        run = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
